// File: rtl/fifo_reservation_station_pkg.sv
// Shared types for the in-order reservation station.
//   rs_state_t       : per-entry lifecycle state
//   add_sub_decode_t : decoded control word carried through the station
package fifo_reservation_station_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    VALID     = 2'd1,
    EXECUTING = 2'd2
  } rs_state_t;

  typedef struct packed {
    logic       sub;
    logic [2:0] flags;
  } add_sub_decode_t;

endpackage

// File: rtl/fifo_reservation_station_if.sv
// Handshake and bus bundle for fifo_reservation_station.
//   take_*   : allocation handshake plus operands/control of the new entry
//   update_* : UPDATE_PORTS result buses (tag + value)
//   output_* : dispatch handshake plus the dispatched entry
//   occupancy: number of live entries
//   flush    : present only when FIFO_RS_FLUSH_EN is defined
// master = upstream/downstream side, slave = the station.
interface fifo_reservation_station_if
  import fifo_reservation_station_pkg::*;
#(
  parameter int  OPERANDS      = 2,
  parameter int  OPERAND_WIDTH = 32,
  parameter int  RS_DEPTH      = 8,
  parameter int  RS_ID_WIDTH   = 5,
  parameter int  UPDATE_PORTS  = 2,
  parameter type CONTROL_TYPE  = add_sub_decode_t
) ();
  localparam int OCC_W = $clog2(RS_DEPTH) + 1;

  logic                                        take_valid;
  logic                                        take_ready;
  logic [OPERANDS-1:0]                         op_value_valid_in;
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]        op_rs_id_in;
  logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_in;
  CONTROL_TYPE                                 control_in;
  logic [RS_ID_WIDTH-1:0]                      id_taken;
  logic [UPDATE_PORTS-1:0]                     update_valid;
  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0]    update_rs_id;
  logic [UPDATE_PORTS-1:0][OPERAND_WIDTH-1:0]  update_value;
  logic                                        output_valid;
  logic                                        output_ready;
  logic                                        no_output;
  logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_out;
  CONTROL_TYPE                                 control_out;
  logic [RS_ID_WIDTH-1:0]                      op_rs_id_out;
  logic [OCC_W-1:0]                            occupancy;
`ifdef FIFO_RS_FLUSH_EN
  logic                                        flush;
`endif

  modport master (
`ifdef FIFO_RS_FLUSH_EN
    output flush,
`endif
    output take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
    output update_valid, update_rs_id, update_value,
    output output_ready, no_output,
    input  take_ready, id_taken, output_valid, op_value_out, control_out,
    input  op_rs_id_out, occupancy
  );

  modport slave (
`ifdef FIFO_RS_FLUSH_EN
    input  flush,
`endif
    input  take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
    input  update_valid, update_rs_id, update_value,
    input  output_ready, no_output,
    output take_ready, id_taken, output_valid, op_value_out, control_out,
    output op_rs_id_out, occupancy
  );

endinterface

// File: rtl/fifo_reservation_station_operand_match.sv
// rs_operand_match: compares one tag against all result buses.
//   tag          : producer RS ID being waited on
//   update_*     : result buses
//   hit          : some valid bus carries the tag
//   value        : value from the lowest-index matching bus
module rs_operand_match
  import fifo_reservation_station_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int RS_ID_WIDTH   = 5,
  parameter int UPDATE_PORTS  = 2
) (
  input  logic [RS_ID_WIDTH-1:0]                      tag,
  input  logic [UPDATE_PORTS-1:0]                     update_valid,
  input  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0]    update_rs_id,
  input  logic [UPDATE_PORTS-1:0][OPERAND_WIDTH-1:0]  update_value,
  output logic                                        hit,
  output logic [OPERAND_WIDTH-1:0]                    value
);

  // Scan high to low so the lowest matching bus index is written last.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int u = UPDATE_PORTS - 1; u >= 0; u--) begin
      if (update_valid[u] && (update_rs_id[u] == tag)) begin
        hit   = 1'b1;
        value = update_value[u];
      end
    end
  end

endmodule

// File: rtl/fifo_reservation_station.sv
// In-order reservation station: circular buffer of RS_DEPTH entries that
// captures operands from UPDATE_PORTS result buses and dispatches in
// allocation order. Entries stay EXECUTING until their own global ID is
// broadcast, unless dispatched with no_output.
//   clk, rst_n : clock, asynchronous active-low reset
//   rs         : fifo_reservation_station_if.slave bundle
// Optional: FIFO_RS_FLUSH_EN adds a synchronous flush input.
//
// state     | meaning
// INVALID   | free, allocatable when write_head reaches it
// VALID     | allocated, waiting for operands and/or dispatch
// EXECUTING | dispatched, waiting for its result broadcast
module fifo_reservation_station
  import fifo_reservation_station_pkg::*;
#(
  parameter int  OPERANDS      = 2,
  parameter int  OPERAND_WIDTH = 32,
  parameter int  RS_OFFSET     = 0,
  parameter int  RS_DEPTH      = 8,
  parameter int  RS_ID_WIDTH   = 5,
  parameter int  UPDATE_PORTS  = 2,
  parameter type CONTROL_TYPE  = add_sub_decode_t
) (
  input logic                        clk,
  input logic                        rst_n,
  fifo_reservation_station_if.slave  rs
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    rs_state_t                              state;
    logic [OPERANDS-1:0]                    op_valid;
    logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]   op_tag;
    logic [OPERANDS-1:0][OPERAND_WIDTH-1:0] op_value;
    CONTROL_TYPE                            control;
  } entry_t;

  entry_t           entry_q [RS_DEPTH];
  entry_t           entry_d [RS_DEPTH];
  logic [IDX_W-1:0] write_head_q, write_head_d;
  logic [IDX_W-1:0] read_head_q, read_head_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  logic [RS_DEPTH-1:0][OPERANDS-1:0] snoop_hit;
  logic [OPERAND_WIDTH-1:0]          snoop_value [RS_DEPTH][OPERANDS];
  logic [OPERANDS-1:0]               take_hit;
  logic [OPERAND_WIDTH-1:0]          take_value [OPERANDS];

  logic take_ready, output_valid, take_fire, dispatch_fire;

  function automatic logic [RS_ID_WIDTH-1:0] global_id(input logic [IDX_W-1:0] idx);
    return RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(idx);
  endfunction

  for (genvar e = 0; e < RS_DEPTH; e++) begin : g_entry
    for (genvar o = 0; o < OPERANDS; o++) begin : g_op
      rs_operand_match #(
        .OPERAND_WIDTH(OPERAND_WIDTH), .RS_ID_WIDTH(RS_ID_WIDTH), .UPDATE_PORTS(UPDATE_PORTS)
      ) u_snoop (
        .tag(entry_q[e].op_tag[o]), .update_valid(rs.update_valid),
        .update_rs_id(rs.update_rs_id), .update_value(rs.update_value),
        .hit(snoop_hit[e][o]), .value(snoop_value[e][o])
      );
    end
  end

  for (genvar o = 0; o < OPERANDS; o++) begin : g_take
    rs_operand_match #(
      .OPERAND_WIDTH(OPERAND_WIDTH), .RS_ID_WIDTH(RS_ID_WIDTH), .UPDATE_PORTS(UPDATE_PORTS)
    ) u_take (
      .tag(rs.op_rs_id_in[o]), .update_valid(rs.update_valid),
      .update_rs_id(rs.update_rs_id), .update_value(rs.update_value),
      .hit(take_hit[o]), .value(take_value[o])
    );
  end

  // Outputs depend on registered state only.
  assign take_ready        = (entry_q[write_head_q].state == INVALID);
  assign output_valid      = (entry_q[read_head_q].state == VALID) && (&entry_q[read_head_q].op_valid);
  assign take_fire         = rs.take_valid && take_ready;
  assign dispatch_fire     = output_valid && rs.output_ready;
  assign rs.take_ready     = take_ready;
  assign rs.id_taken       = take_ready ? global_id(write_head_q) : RS_ID_WIDTH'(RS_OFFSET);
  assign rs.output_valid   = output_valid;
  assign rs.op_value_out   = entry_q[read_head_q].op_value;
  assign rs.control_out    = entry_q[read_head_q].control;
  assign rs.op_rs_id_out   = global_id(read_head_q);
  assign rs.occupancy      = occupancy_q;

  always_comb begin
    entry_d      = entry_q;
    write_head_d = write_head_q;
    read_head_d  = read_head_q;

    for (int e = 0; e < RS_DEPTH; e++) begin
      if (entry_q[e].state == VALID) begin
        for (int o = 0; o < OPERANDS; o++) begin
          if (!entry_q[e].op_valid[o] && snoop_hit[e][o]) begin
            entry_d[e].op_valid[o] = 1'b1;
            entry_d[e].op_value[o] = snoop_value[e][o];
          end
        end
      end else if (entry_q[e].state == EXECUTING) begin
        for (int u = 0; u < UPDATE_PORTS; u++) begin
          if (rs.update_valid[u] && (rs.update_rs_id[u] == global_id(IDX_W'(e))))
            entry_d[e].state = INVALID;
        end
      end
    end

    // Dispatch and take never target the same entry: one needs VALID, the other INVALID.
    if (dispatch_fire) begin
      entry_d[read_head_q].state = rs.no_output ? INVALID : EXECUTING;
      read_head_d = read_head_q + 1'b1;
    end

    if (take_fire) begin
      entry_d[write_head_q].state   = VALID;
      entry_d[write_head_q].control = rs.control_in;
      for (int o = 0; o < OPERANDS; o++) begin
        entry_d[write_head_q].op_tag[o] = rs.op_rs_id_in[o];
        if (rs.op_value_valid_in[o]) begin
          entry_d[write_head_q].op_valid[o] = 1'b1;
          entry_d[write_head_q].op_value[o] = rs.op_value_in[o];
        end else begin
          entry_d[write_head_q].op_valid[o] = take_hit[o];
          entry_d[write_head_q].op_value[o] = take_hit[o] ? take_value[o] : '0;
        end
      end
      write_head_d = write_head_q + 1'b1;
    end

`ifdef FIFO_RS_FLUSH_EN
    if (rs.flush) begin
      for (int e = 0; e < RS_DEPTH; e++) entry_d[e].state = INVALID;
      write_head_d = '0;
      read_head_d  = '0;
    end
`endif

    occupancy_d = '0;
    for (int e = 0; e < RS_DEPTH; e++) begin
      if (entry_d[e].state != INVALID) occupancy_d = occupancy_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < RS_DEPTH; e++) entry_q[e] <= '0;
      write_head_q <= '0;
      read_head_q  <= '0;
      occupancy_q  <= '0;
    end else begin
      for (int e = 0; e < RS_DEPTH; e++) entry_q[e] <= entry_d[e];
      write_head_q <= write_head_d;
      read_head_q  <= read_head_d;
      occupancy_q  <= occupancy_d;
    end
  end

endmodule
